// File: rtl/countdown_timer.sv
// countdown_timer: prescaled countdown with IDLE/RUN/DONE control; `define COUNTDOWN_TIMER_AUTO_RELOAD_EN for auto-reload
module countdown_timer #(
  parameter int DIV     = 50000000,
  parameter int COUNT_W = 5,
  parameter int START   = 24
) (
  input  logic               cin,
  input  logic               rst_n,
  input  logic               start,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               en,
  output logic               cout,
  output logic               tick,
  output logic [COUNT_W-1:0] out_count,
  output logic               done
);
  localparam int PW = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d, pulse_q, pulse_d;
  logic wrap;
  assign wrap = state_q == RUN && en && psc_q == PW'(DIV - 1);
  // next state: load beats start beats wrap; a load/start edge swallows any coincident wrap
  always_comb begin
    state_d = state_q;
    psc_d   = state_q == RUN ? psc_q : '0;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    pulse_d = 1'b0;
    if (load) begin
      state_d = load_val == '0 ? DONE : RUN;
      psc_d   = '0;
      cnt_d   = load_val;
    end else if (start) begin
      state_d = RUN;
      psc_d   = '0;
      cnt_d   = COUNT_W'(START);
    end else if (state_q == RUN && en) begin
      psc_d = wrap ? '0 : psc_q + 1'b1;
      if (wrap) begin
        tick_d = 1'b1;
        if (cnt_q <= COUNT_W'(1)) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          cnt_d   = COUNT_W'(START);
          pulse_d = 1'b1;
`else
          cnt_d   = '0;
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge cin) begin
    if (!rst_n) begin
      state_q <= IDLE;
      psc_q   <= '0;
      cnt_q   <= COUNT_W'(START);
      tick_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      pulse_q <= pulse_d;
    end
  end
  assign cout      = state_q == RUN && psc_q >= PW'(DIV / 2);
  assign tick      = tick_q;
  assign out_count = cnt_q;
  assign done      = state_q == DONE || pulse_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table vectors, directed corner sequences and randomized run against a cycle-count model
module tb_countdown_timer;
  localparam int DIV = 4;
  localparam int COUNT_W = 5;
  localparam int START = 3;
  logic cin = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, load = 1'b0, en = 1'b0;
  logic [COUNT_W-1:0] load_val = '0;
  logic cout, tick, done;
  logic [COUNT_W-1:0] out_count;
  int checks = 0, errors = 0;
  // model: a countdown is "base" minus whole periods of enabled cycles elapsed since it began
  bit m_run, m_fin, m_tick, m_pulse;
  int m_base = START, m_n = 0;

  countdown_timer #(.DIV(DIV), .COUNT_W(COUNT_W), .START(START)) dut (
    .cin(cin), .rst_n(rst_n), .start(start), .load(load), .load_val(load_val),
    .en(en), .cout(cout), .tick(tick), .out_count(out_count), .done(done)
  );

  always #5 cin = ~cin;

  typedef struct {
    logic rst_n, start, load;
    logic [COUNT_W-1:0] lv;
    logic en;
    int cnt;
    logic tick, done, cout;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(logic r, logic s, logic l, int lv, logic e, int c, logic t, logic d, logic co);
    vec_t v;
    v.rst_n = r; v.start = s; v.load = l; v.lv = COUNT_W'(lv); v.en = e;
    v.cnt = c; v.tick = t; v.done = d; v.cout = co;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_tick = 0;
    m_pulse = 0;
    if (!rst_n) begin
      m_run = 0; m_fin = 0; m_base = START; m_n = 0;
    end else if (load) begin
      m_base = int'(load_val); m_n = 0; m_run = load_val != 0; m_fin = load_val == 0;
    end else if (start) begin
      m_base = START; m_n = 0; m_run = 1; m_fin = 0;
    end else if (m_run && en) begin
      m_n++;
      m_tick = (m_n % DIV) == 0;
      if (m_n == m_base * DIV) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        m_pulse = 1; m_base = START; m_n = 0;
`else
        m_run = 0; m_fin = 1;
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge cin);
    model_edge();
    @(negedge cin);
  endtask

  task automatic cmp_model(input string tag);
    int ec;
    ec = m_run ? m_base - m_n / DIV : (m_fin ? 0 : m_base);
    chk({tag, ".count"}, int'(out_count), ec);
    chk({tag, ".tick"}, int'(tick), int'(m_tick));
    chk({tag, ".done"}, int'(done), int'(m_fin || m_pulse));
    chk({tag, ".cout"}, int'(cout), int'(m_run && (m_n % DIV) >= DIV / 2));
  endtask

  task automatic drive(input logic r, input logic s, input logic l, input int lv, input logic e);
    rst_n = r; start = s; load = l; load_val = COUNT_W'(lv); en = e;
  endtask

  initial begin
    int tick_at, ndone, nprev;
    int seen[$];
    // reset, start, then a full countdown: 3,2,1,0 every 4 cycles with cout 0,0,1,1
    tbl[0]  = mk(0, 0, 0, 0, 0, 3, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 3, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 1, 3, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 1, 3, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 1, 3, 0, 0, 1);
    tbl[5]  = mk(1, 0, 0, 0, 1, 3, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 0, 1, 2, 1, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 1, 2, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 1, 2, 0, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0, 1, 2, 0, 0, 1);
    tbl[10] = mk(1, 0, 0, 0, 1, 1, 1, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 1, 1, 0, 0, 1);
    tbl[13] = mk(1, 0, 0, 0, 1, 1, 0, 0, 1);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    tbl[14] = mk(1, 0, 0, 0, 1, 3, 1, 1, 0);
    tbl[15] = mk(1, 0, 0, 0, 1, 3, 0, 0, 0);
`else
    tbl[14] = mk(1, 0, 0, 0, 1, 0, 1, 1, 0);
    tbl[15] = mk(1, 0, 0, 0, 1, 0, 0, 1, 0);
`endif
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst_n, tbl[i].start, tbl[i].load, int'(tbl[i].lv), tbl[i].en);
      step();
      chk($sformatf("vec%0d.count", i), int'(out_count), tbl[i].cnt);
      chk($sformatf("vec%0d.tick", i), int'(tick), int'(tbl[i].tick));
      chk($sformatf("vec%0d.done", i), int'(done), int'(tbl[i].done));
      chk($sformatf("vec%0d.cout", i), int'(cout), int'(tbl[i].cout));
    end

    // pause mid-period: everything freezes and the first tick slips by 5 cycles
    drive(1, 1, 0, 0, 1); step();
    tick_at = 0;
    drive(1, 0, 0, 0, 1); step(); step();
    cmp_model("pre_pause");
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pause.count", int'(out_count), 3);
      chk("pause.cout", int'(cout), 1);
      chk("pause.tick", int'(tick), 0);
    end
    drive(1, 0, 0, 0, 1);
    for (int i = 8; i < 30 && tick_at == 0; i++) begin
      step();
      if (tick) tick_at = i;
    end
    chk("pause.tick_cycle", tick_at, 9);
    cmp_model("post_pause");

    // load coinciding with a wrap: no tick, count 7, prescaler restarts
    drive(1, 1, 0, 0, 1); step();
    drive(1, 0, 0, 0, 1); step(); step(); step();
    drive(1, 0, 1, 7, 1); step();
    chk("load_wrap.count", int'(out_count), 7);
    chk("load_wrap.tick", int'(tick), 0);
    chk("load_wrap.cout", int'(cout), 0);
    drive(1, 0, 0, 0, 1); step();
    cmp_model("load_wrap+1");
    step();
    chk("load_wrap+2.cout", int'(cout), 1);

    // load zero from RUN lands straight in DONE
    drive(1, 0, 1, 0, 1); step();
    chk("load0.done", int'(done), 1);
    chk("load0.cout", int'(cout), 0);
    chk("load0.count", int'(out_count), 0);
    drive(1, 0, 0, 0, 1); step();
    cmp_model("load0+1");

    // reset mid-countdown wins over load and start
    drive(1, 1, 0, 0, 1); step();
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst.count", int'(out_count), 2);
    chk("pre_rst.cout", int'(cout), 1);
    drive(0, 1, 1, 9, 1); step();
    chk("rst.count", int'(out_count), 3);
    chk("rst.done", int'(done), 0);
    chk("rst.tick", int'(tick), 0);
    chk("rst.cout", int'(cout), 0);
    drive(1, 0, 0, 0, 1); step();
    chk("idle_hold.count", int'(out_count), 3);
    cmp_model("idle_hold");

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // auto-reload: ticks show 2,1,3,2,1,3 and done pulses one cycle per reload
    drive(1, 1, 0, 0, 1); step();
    drive(1, 0, 0, 0, 1);
    ndone = 0; nprev = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      cmp_model("auto");
      if (tick) seen.push_back(int'(out_count));
      if (done) ndone++;
      chk("auto.done_single", int'(done && nprev == 1), 0);
      nprev = int'(done);
    end
    chk("auto.done_pulses", ndone, 2);
    chk("auto.ticks", seen.size(), 6);
    if (seen.size() == 6) begin
      chk("auto.seq0", seen[0], 2); chk("auto.seq1", seen[1], 1); chk("auto.seq2", seen[2], 3);
      chk("auto.seq3", seen[3], 2); chk("auto.seq4", seen[4], 1); chk("auto.seq5", seen[5], 3);
    end
`endif

    // randomized traffic checked every cycle against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(39) != 0, $urandom_range(14) == 0, $urandom_range(19) == 0,
            $urandom_range(3) == 0 ? 0 : ($urandom_range(7) == 0 ? int'($urandom_range(31)) : int'($urandom_range(5))),
            $urandom_range(3) != 0);
      step();
      cmp_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter DIV, default 50000000, prescaler input-clock cycles per tick; legal range DIV >= 2.
REQ-002 SHALL have parameter COUNT_W, default 5, width of out_count.
REQ-003 SHALL have parameter START, default 24, countdown start value; legal range 1 to 2^COUNT_W-1.
REQ-004 SHALL size the prescaler register at $clog2(DIV) bits.
REQ-005 SHALL have port cin, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: begin the countdown from START.
REQ-008 SHALL have port load, input, 1 bit: begin the countdown from load_val.
REQ-009 SHALL have port load_val, input, COUNT_W bits: start value used with load.
REQ-010 SHALL have port en, input, 1 bit: prescaler advance enable (pause when low).
REQ-011 SHALL have port cout, output, 1 bit: divided clock.
REQ-012 SHALL have port tick, output, 1 bit: one-cycle pulse per prescaler period.
REQ-013 SHALL have port out_count, output, COUNT_W bits: current countdown value.
REQ-014 SHALL have port done, output, 1 bit: countdown has reached zero.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 Transitions SHALL be:
- IDLE --start--> RUN
- RUN --last decrement--> DONE
- DONE --start--> RUN
- any state --load--> RUN, or DONE when load_val == 0
REQ-017 Priority SHALL be: rst_n low, then load, then start, then a prescaler wrap.
REQ-018 On start, the block SHALL set out_count = START and prescaler = 0.
REQ-019 On load, the block SHALL set out_count = load_val and prescaler = 0.
REQ-020 When load or start coincides with a prescaler wrap, the wrap SHALL be discarded and no tick or decrement SHALL occur.
REQ-021 In RUN with en = 1, the prescaler SHALL increment each cycle and wrap from DIV-1 to 0.
REQ-022 In RUN with en = 0, the prescaler, out_count and cout SHALL hold their values.
REQ-023 In IDLE and DONE, the prescaler SHALL be held at 0.
REQ-024 tick SHALL be registered and high for exactly one cycle, the cycle after the prescaler wraps.
REQ-025 tick SHALL occur exactly once per DIV enabled cycles.
REQ-026 On each wrap in RUN, out_count SHALL decrement by 1.
REQ-027 The wrap that takes out_count from 1 to 0 SHALL move the state to DONE on the same edge.
REQ-028 out_count SHALL never wrap below 0.
REQ-029 cout SHALL be 0 while prescaler < DIV/2 (integer division) and 1 otherwise.
REQ-030 cout SHALL be forced to 0 outside RUN.
REQ-031 done SHALL be 1 exactly while the state is DONE.
REQ-032 start in RUN SHALL restart the countdown from START.

Reset
REQ-033 While rst_n = 0 at a rising edge of cin, the block SHALL enter IDLE with prescaler = 0, out_count = START, tick = 0, done = 0 and cout = 0.
REQ-034 Reset SHALL take effect mid-countdown and override load and start.
REQ-035 Reset SHALL have no asynchronous path.

Configuration
REQ-036 The macro COUNTDOWN_TIMER_AUTO_RELOAD_EN SHALL control auto-reload.
REQ-037 With COUNTDOWN_TIMER_AUTO_RELOAD_EN defined:
- the wrap that would reach 0 SHALL instead reload out_count = START and stay in RUN;
- done SHALL pulse high for that one cycle;
- DONE is reachable only via load with load_val = 0.
REQ-038 Without COUNTDOWN_TIMER_AUTO_RELOAD_EN, behaviour SHALL be REQ-026 to REQ-031: stop in DONE holding out_count = 0.

Verification (DIV = 4, START = 3, COUNT_W = 5)
REQ-039 The bench SHALL apply rst_n low for 2 cycles, then start with en = 1 -> out_count 3,2,1,0 at 4-cycle spacing; tick 3 times; done = 1 after the 12th enabled cycle; cout pattern 0,0,1,1 per period.
REQ-040 The bench SHALL drop en for 5 cycles mid-period -> prescaler, cout and out_count frozen; the next tick is delayed by exactly 5 cycles.
REQ-041 The bench SHALL assert load with load_val = 7 on the same edge as a wrap -> out_count = 7, prescaler = 0, no tick that cycle.
REQ-042 The bench SHALL assert load with load_val = 0 from RUN -> DONE next cycle, done = 1, cout = 0.
REQ-043 The bench SHALL drop rst_n while out_count = 2 in RUN -> IDLE, out_count = 3, all outputs at reset values the next cycle.
REQ-044 The bench SHALL run with COUNTDOWN_TIMER_AUTO_RELOAD_EN defined -> sequence 3,2,1,3,2,1 with a one-cycle done pulse at each reload; state never DONE.
